// File: rtl/oob_signal_detector_pkg.sv
// ============================================================================
// Module : oob_signal_detector_pkg
// Brief  : Shared OOB timing defaults (75 MHz clk) and gap classification.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package oob_signal_detector_pkg;

    localparam int CNT_W = 8;

    // Default burst/gap windows in clk cycles at 75 MHz.
    localparam int DEF_BURST_MIN    = 5;
    localparam int DEF_BURST_MAX    = 11;
    localparam int DEF_WAKE_GAP_MIN = 3;
    localparam int DEF_WAKE_GAP_MAX = 12;
    localparam int DEF_INIT_GAP_MIN = 14;
    localparam int DEF_INIT_GAP_MAX = 39;
    localparam int DEF_DETECT_GAPS  = 4;

    typedef enum logic [1:0] {
        KIND_INVALID = 2'd0,
        KIND_WAKE    = 2'd1,
        KIND_INIT    = 2'd2
    } gap_kind_t;

    function automatic gap_kind_t classify_gap(
        input logic [CNT_W-1:0] len,
        input logic [CNT_W-1:0] wake_min,
        input logic [CNT_W-1:0] wake_max,
        input logic [CNT_W-1:0] init_min,
        input logic [CNT_W-1:0] init_max
    );
        if (len >= wake_min && len <= wake_max) begin
            return KIND_WAKE;
        end
        if (len >= init_min && len <= init_max) begin
            return KIND_INIT;
        end
        return KIND_INVALID;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oob_signal_detector.sv
// ============================================================================
// Module : oob_signal_detector
// Brief  : Detects SATA COMINIT/COMRESET and COMWAKE from the elec-idle flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oob_signal_detector
    import oob_signal_detector_pkg::*;
#(
    parameter int BURST_MIN    = DEF_BURST_MIN,
    parameter int BURST_MAX    = DEF_BURST_MAX,
    parameter int WAKE_GAP_MIN = DEF_WAKE_GAP_MIN,
    parameter int WAKE_GAP_MAX = DEF_WAKE_GAP_MAX,
    parameter int INIT_GAP_MIN = DEF_INIT_GAP_MIN,
    parameter int INIT_GAP_MAX = DEF_INIT_GAP_MAX,
    parameter int DETECT_GAPS  = DEF_DETECT_GAPS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_is_elec_idle,
    output logic       comm_init_detect,
    output logic       comm_wake_detect,
    output logic [1:0] oob_det_state
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_BURST       = 2'd1,
        S_GAP         = 2'd2,
        S_LONG_ACTIVE = 2'd3
    } state_t;

    // Windows must stay below the 8-bit saturation point and the wake
    // window must end before the init window starts.
    localparam logic [CNT_W-1:0] C_BURST_MIN    = CNT_W'(BURST_MIN);
    localparam logic [CNT_W-1:0] C_BURST_MAX    = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] C_WAKE_GAP_MIN = CNT_W'(WAKE_GAP_MIN);
    localparam logic [CNT_W-1:0] C_WAKE_GAP_MAX = CNT_W'(WAKE_GAP_MAX);
    localparam logic [CNT_W-1:0] C_INIT_GAP_MIN = CNT_W'(INIT_GAP_MIN);
    localparam logic [CNT_W-1:0] C_INIT_GAP_MAX = CNT_W'(INIT_GAP_MAX);
    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_SAT      = {CNT_W{1'b1}};

    localparam int               GC_W    = $clog2(DETECT_GAPS + 1);
    localparam logic [GC_W-1:0]  GC_FULL = GC_W'(DETECT_GAPS);
    localparam logic [GC_W-1:0]  GC_ONE  = GC_W'(1);

    logic             idle_q;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [GC_W-1:0]  gap_count, gap_count_n;
    gap_kind_t        last_class, last_class_n, gap_kind;
    logic             init_det, wake_det;
    logic             clear_pattern;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q     <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            gap_count  <= '0;
            last_class <= KIND_INIT;
            init_det   <= 1'b0;
            wake_det   <= 1'b0;
        end else begin
            idle_q     <= rx_is_elec_idle;
            state      <= state_n;
            cnt        <= cnt_n;
            gap_count  <= gap_count_n;
            last_class <= last_class_n;
            init_det   <= (gap_count_n == GC_FULL) && (last_class_n == KIND_INIT);
            wake_det   <= (gap_count_n == GC_FULL) && (last_class_n == KIND_WAKE);
        end
    end

    assign cnt_inc  = (cnt == C_CNT_SAT) ? cnt : cnt + C_ONE;
    assign gap_kind = classify_gap(cnt, C_WAKE_GAP_MIN, C_WAKE_GAP_MAX,
                                   C_INIT_GAP_MIN, C_INIT_GAP_MAX);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        gap_count_n   = gap_count;
        last_class_n  = last_class;
        clear_pattern = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!idle_q) begin
                    state_n = S_BURST;
                    cnt_n   = C_ONE;
                end else begin
                    cnt_n   = '0;
                end
            end

            S_BURST: begin
                if (!idle_q) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc > C_BURST_MAX) begin
                        state_n       = S_LONG_ACTIVE;
                        clear_pattern = 1'b1;
                    end
                end else if (cnt < C_BURST_MIN) begin
                    state_n       = S_IDLE;
                    cnt_n         = '0;
                    clear_pattern = 1'b1;
                end else begin
                    state_n = S_GAP;
                    cnt_n   = C_ONE;
                end
            end

            S_GAP: begin
                if (idle_q) begin
                    cnt_n = cnt_inc;
                    // Silence past the init window ends the pattern.
                    if (cnt_inc > C_INIT_GAP_MAX) begin
                        state_n       = S_IDLE;
                        cnt_n         = '0;
                        clear_pattern = 1'b1;
                    end
                end else begin
                    state_n = S_BURST;
                    cnt_n   = C_ONE;
                    if (gap_kind == KIND_INVALID) begin
                        clear_pattern = 1'b1;
                    end else if (gap_kind == last_class) begin
                        gap_count_n = (gap_count == GC_FULL) ? GC_FULL
                                                             : gap_count + GC_ONE;
                    end else begin
                        gap_count_n  = GC_ONE;
                        last_class_n = gap_kind;
                    end
                end
            end

            S_LONG_ACTIVE: begin
                cnt_n = cnt_inc;
                if (idle_q) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
        endcase

        if (clear_pattern) begin
            gap_count_n = '0;
        end
    end

    assign comm_init_detect = init_det;
    assign comm_wake_detect = wake_det;
    assign oob_det_state    = state;

endmodule

`default_nettype wire

// File: tb/tb_oob_signal_detector.sv
// ============================================================================
// Module : tb_oob_signal_detector
// Brief  : Directed OOB patterns checked against a run-length reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oob_signal_detector;

    localparam int BMIN  = 5;
    localparam int BMAX  = 11;
    localparam int WMIN  = 3;
    localparam int WMAX  = 12;
    localparam int IMIN  = 14;
    localparam int IMAX  = 39;
    localparam int NGAPS = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       init_det;
    logic       wake_det;
    logic [1:0] det_state;

    int total = 0;
    int bad   = 0;

    oob_signal_detector dut (
        .clk              (clk),
        .rst              (rst),
        .rx_is_elec_idle  (rx),
        .comm_init_detect (init_det),
        .comm_wake_detect (wake_det),
        .oob_det_state    (det_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: reasons about run lengths of the sampled idle flag.
    // A gap counts only when it follows a legal burst; a streak of same-class
    // gaps reaching NGAPS raises the matching detect.
    int m_cap;       // rx captured at the last edge (what the detector samples)
    int m_last;      // sample most recently judged
    int m_run_act;   // length of current active run
    int m_run_idle;  // length of current idle run
    int m_armed;     // current idle run follows a legal burst
    int m_streak;
    int m_cls;       // 0 = wake, 1 = init

    task automatic model_reset();
        m_cap = 1; m_last = 1; m_run_act = 0; m_run_idle = 0;
        m_armed = 0; m_streak = 0; m_cls = 1;
    endtask

    task automatic model_classify(input int g);
        int k;
        if (g >= WMIN && g <= WMAX)      k = 0;
        else if (g >= IMIN && g <= IMAX) k = 1;
        else                             k = -1;
        if (k < 0) begin
            m_streak = 0;
        end else if (k == m_cls) begin
            m_streak = (m_streak + 1 > NGAPS) ? NGAPS : m_streak + 1;
        end else begin
            m_streak = 1;
            m_cls    = k;
        end
    endtask

    task automatic model_step();
        int s;
        s = m_cap;
        if (s == 0) begin
            if (m_last == 1) begin
                if (m_armed != 0) model_classify(m_run_idle);
                m_armed   = 0;
                m_run_act = 0;
            end
            m_run_act++;
            if (m_run_act > BMAX) m_streak = 0;
        end else begin
            if (m_last == 0) begin
                m_armed = (m_run_act >= BMIN && m_run_act <= BMAX) ? 1 : 0;
                if (m_run_act < BMIN) m_streak = 0;
                m_run_idle = 0;
            end
            m_run_idle++;
            if (m_armed != 0 && m_run_idle > IMAX) begin
                m_streak = 0;
                m_armed  = 0;
            end
        end
        m_last = s;
        m_cap  = int'(rx);
    endtask

    function automatic int exp_init();
        return (m_streak >= NGAPS && m_cls == 1) ? 1 : 0;
    endfunction

    function automatic int exp_wake();
        return (m_streak >= NGAPS && m_cls == 0) ? 1 : 0;
    endfunction

    function automatic int exp_state();
        if (m_last == 0) return (m_run_act > BMAX) ? 3 : 1;
        return (m_armed != 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("init_vs_model",  int'(init_det),  exp_init());
            check("wake_vs_model",  int'(wake_det),  exp_wake());
            check("state_vs_model", int'(det_state), exp_state());
            check("detects_exclusive", int'(init_det & wake_det), 0);
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic burst_gap(input int b, input int g);
        drive(1'b0, b);
        drive(1'b1, g);
    endtask

    // Start the next burst and look at the detect two edges later.
    task automatic probe_after_gap(input string name, input logic want_init,
                                   input logic want_wake);
        drive(1'b0, 1);
        @(negedge clk);
        check({name, "_pre_init"}, int'(init_det), 0);
        @(negedge clk);
        check({name, "_init"}, int'(init_det), int'(want_init));
        check({name, "_wake"}, int'(wake_det), int'(want_wake));
        drive(1'b0, 5);
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", int'(det_state), 0);
        check("reset_init",  int'(init_det), 0);
        check("reset_wake",  int'(wake_det), 0);
        #2 rst = 1'b0;

        // COMINIT: rise two edges into burst 5, fall 41 edges after burst 6.
        repeat (4) burst_gap(8, 24);
        probe_after_gap("cominit", 1'b1, 1'b0);
        drive(1'b1, 24);
        drive(1'b0, 8);
        drive(1'b1, 1);
        repeat (40) @(negedge clk);
        check("cominit_hold_40", int'(init_det), 1);
        @(negedge clk);
        check("cominit_fall_41", int'(init_det), 0);
        drive(1'b1, 5);

        // COMWAKE
        repeat (4) burst_gap(8, 8);
        probe_after_gap("comwake", 1'b0, 1'b1);
        drive(1'b1, 8);
        burst_gap(8, 45);
        check("comwake_timeout", int'(wake_det), 0);

        // Normal data: long active run
        drive(1'b0, 40);
        check("long_state", int'(det_state), 3);
        check("long_init",  int'(init_det), 0);
        check("long_wake",  int'(wake_det), 0);
        drive(1'b1, 5);

        // Over-long third gap restarts the count
        burst_gap(8, 24);
        burst_gap(8, 24);
        burst_gap(8, 50);
        repeat (3) burst_gap(8, 24);
        probe_after_gap("gap50_three", 1'b0, 1'b0);
        drive(1'b1, 24);
        probe_after_gap("gap50_four", 1'b1, 1'b0);
        drive(1'b1, 45);

        // Reset during the third wake burst
        burst_gap(8, 8);
        burst_gap(8, 8);
        drive(1'b0, 3);
        #2 rst = 1'b1;
        #1;
        check("midrst_state", int'(det_state), 0);
        check("midrst_init",  int'(init_det), 0);
        check("midrst_wake",  int'(wake_det), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 7);
        drive(1'b1, 8);
        repeat (2) burst_gap(8, 8);
        drive(1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        check("postrst_three_gaps", int'(wake_det), 0);
        drive(1'b0, 5);
        drive(1'b1, 8);
        probe_after_gap("postrst_four_gaps", 1'b0, 1'b1);
        drive(1'b1, 45);

        // Wake gaps then init gaps: class change restarts the streak
        burst_gap(8, 8);
        burst_gap(8, 8);
        repeat (3) burst_gap(8, 24);
        probe_after_gap("mixed_three", 1'b0, 1'b0);
        drive(1'b1, 24);
        probe_after_gap("mixed_four", 1'b1, 1'b0);
        drive(1'b1, 45);

        // Window boundaries: burst 5/11/4/12, gaps 12/13/39/14
        burst_gap(5, 12);
        burst_gap(11, 13);
        burst_gap(5, 39);
        burst_gap(11, 14);
        burst_gap(4, 20);
        burst_gap(12, 10);
        burst_gap(5, 40);
        repeat (4) burst_gap(11, 12);
        probe_after_gap("wake_edges", 1'b0, 1'b1);
        drive(1'b1, 45);
        repeat (4) burst_gap(5, 39);
        probe_after_gap("init_edges", 1'b1, 1'b0);
        drive(1'b1, 45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oob_signal_detector.md
OOB_SIGNAL_DETECTOR -- requirements
Module: oob_signal_detector

Interface
REQ-001 Parameter BURST_MIN, default 5: minimum legal burst length, in clk cycles.
REQ-002 Parameter BURST_MAX, default 11: maximum legal burst length, in cycles.
REQ-003 Parameter WAKE_GAP_MIN, default 3; WAKE_GAP_MAX, default 12: COMWAKE gap window, in cycles.
REQ-004 Parameter INIT_GAP_MIN, default 14; INIT_GAP_MAX, default 39: COMINIT gap window, in cycles.
REQ-005 Parameter DETECT_GAPS, default 4: number of consecutive same-class valid gaps that declares a detect.
REQ-006 Parameter defaults assume a 75 MHz clk.
REQ-007 clk  in  1: single clock, shared with the OOB controller.
REQ-008 rst  in  1: reset; asynchronous, active-high.
REQ-009 rx_is_elec_idle  in  1: transceiver electrical-idle flag, synchronous to clk.
REQ-010 comm_init_detect  out  1: COMINIT/COMRESET pattern present.
REQ-011 comm_wake_detect  out  1: COMWAKE pattern present.
REQ-012 oob_det_state  out  2: current FSM state, for debug.

Function
REQ-013 Sample rx_is_elec_idle into one register (idle_q); all logic SHALL use idle_q only.
- Detect latency = sample register + classification cycle.

REQ-014 FSM states: IDLE=0, BURST=1, GAP=2, LONG_ACTIVE=3.
- IDLE: idle_q=0 -> BURST, cnt=1.

REQ-015 BURST: cnt increments while idle_q=0.
- cnt > BURST_MAX -> LONG_ACTIVE; clear gap_count and both detects.
- idle_q=1 with cnt < BURST_MIN -> IDLE; clear gap_count.
- idle_q=1 with cnt in [BURST_MIN, BURST_MAX] -> GAP, cnt=1.

REQ-016 LONG_ACTIVE: remain until idle_q=1, then -> IDLE.

REQ-017 GAP: cnt increments while idle_q=1.
- cnt > INIT_GAP_MAX -> IDLE; clear gap_count and both detects (pattern ended).

REQ-018 GAP, idle_q falls: classify cnt as WAKE (in wake window), INIT (in init window) or invalid.
- Invalid -> clear gap_count; -> BURST, cnt=1.

REQ-019 Valid gap, same class as last_class: gap_count += 1, saturating at DETECT_GAPS.
- Different class: gap_count=1, last_class updated.
- Either case -> BURST, cnt=1.

REQ-020 gap_count reaches DETECT_GAPS: assert the detect matching last_class on the next cycle.
- Detect holds until cleared per REQ-015/017/018.

REQ-021 comm_init_detect and comm_wake_detect SHALL never be high simultaneously; a class change clears the other detect in the same cycle.

REQ-022 cnt is 8 bits, saturating at 255; no wrap.
- Parameters SHALL satisfy BURST_MAX, INIT_GAP_MAX < 255 and WAKE_GAP_MAX < INIT_GAP_MIN.

Reset
REQ-023 rst asserted (asynchronous): state=IDLE; cnt=0, gap_count=0, last_class=INIT, idle_q=1; both detects 0.
REQ-024 rst mid-sequence discards all partial counts; detection restarts from IDLE on the first non-idle sample after release.

Structure
REQ-025 Default timing constants (burst/gap windows, DETECT_GAPS) SHALL live in the shared SATA defines include, beside the primitive definitions.
REQ-026 State encodings are local parameters.
REQ-027 Single module, no sub-module; counters are inline.

Verification
REQ-028 6 bursts of 8 cycles, gaps of 24 cycles -> comm_init_detect rises 2 cycles after the 4th gap ends.
- Falls 41 cycles after the last burst ends; comm_wake_detect stays 0.
REQ-029 6 bursts of 8 cycles, gaps of 8 cycles -> comm_wake_detect rises after the 4th gap.
- comm_init_detect stays 0 throughout.
REQ-030 Continuous non-idle for 40 cycles (normal data) -> LONG_ACTIVE; no detect asserted.
REQ-031 INIT sequence whose 3rd gap is 50 cycles -> gap_count clears; no detect until 4 further valid gaps.
REQ-032 rst pulsed during the 3rd burst of a wake pattern -> outputs 0 immediately; a full new pattern is required before detect.
REQ-033 Two 8-cycle wake gaps, then 24-cycle init gaps -> comm_init_detect asserts only after the 4th init gap; never both detects high.
